// File: rtl/reg_xfer_arbiter_pkg.sv
// Shared encodings and default widths for the swap-staged register transfer arbiter.
package reg_xfer_arbiter_pkg;

  localparam int unsigned XFER_DW   = 18;
  localparam int unsigned XFER_NREG = 4;
  localparam int unsigned XFER_IW   = 2;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_INC  = 2'b01,
    OP_DEC  = 2'b10,
    OP_ILL  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    STAGE  = 2'b01,
    COMMIT = 2'b10,
    DONE   = 2'b11
  } state_e;

endpackage

// File: rtl/reg_xfer_arbiter_arb.sv
// Two-way round-robin grant; the pointer flips to the other requester whenever a grant is taken.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic       gnt_valid,
  output logic       gnt_id
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt_valid = |req;
    // On a tie the pointer decides; otherwise the lone requester wins.
    gnt_id    = (req == 2'b11) ? ptr_q : req[1];
    ptr_d     = ptr_q;
    if (grant_en && gnt_valid) ptr_d = ~gnt_id;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr_q <= 1'b0;
    else      ptr_q <= ptr_d;
  end

endmodule

// File: rtl/reg_xfer_arbiter.sv
// Arbitrates two requesters onto one swap-staged register bank and sequences stage/commit.
module reg_xfer_arbiter
  import reg_xfer_arbiter_pkg::*;
#(
  parameter int unsigned NREG = XFER_NREG,
  parameter int unsigned DW   = XFER_DW,
  parameter int unsigned IW   = XFER_IW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0,
  input  logic [1:0]      op0,
  input  logic [IW-1:0]   idx0,
  input  logic [DW-1:0]   wdata0,
  input  logic            req1,
  input  logic [1:0]      op1,
  input  logic [IW-1:0]   idx1,
  input  logic [DW-1:0]   wdata1,
  output logic            ack0,
  output logic            ack1,
  output logic            err,
  output logic [NREG-1:0] en,
  output logic            inc,
  output logic            dec,
  output logic            swp1,
  output logic            swp2,
  output logic [DW-1:0]   bus4,
  output logic            busy,
  output state_e          dbg_state
);

  state_e        state_q, state_d;
  op_e           op_q, op_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          id_q, id_d;
  logic          err_q, err_d;

  logic          gnt_valid, gnt_id, grant_en;
  logic [1:0]    sel_op;
  logic [IW-1:0] sel_idx;
  logic [DW-1:0] sel_wdata;
  logic          sel_err;
  logic [NREG-1:0] en_dec;
  logic [DW-1:0]   bus_val;

  assign grant_en = (state_q == IDLE);

  rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       ({req1, req0}),
    .grant_en  (grant_en),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  always_comb begin
    sel_op    = gnt_id ? op1    : op0;
    sel_idx   = gnt_id ? idx1   : idx0;
    sel_wdata = gnt_id ? wdata1 : wdata0;
    sel_err   = (sel_op == OP_ILL) || (int'(sel_idx) >= int'(NREG));

    state_d = state_q;
    op_d    = op_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    id_d    = id_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          op_d    = op_e'(sel_op);
          idx_d   = sel_idx;
          wdata_d = sel_wdata;
          id_d    = gnt_id;
          err_d   = sel_err;
          // Bad requests never touch the bank: skip straight to the ack.
          state_d = sel_err ? DONE : STAGE;
        end
      end
      STAGE:   state_d = COMMIT;
      COMMIT:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      op_q    <= OP_LOAD;
      idx_q   <= '0;
      wdata_q <= '0;
      id_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      id_q    <= id_d;
      err_q   <= err_d;
    end
  end

  // Strobes decode straight from flops so they settle well before the bank's negedge.
  always_comb begin
    en_dec  = NREG'(1) << idx_q;
    bus_val = (op_q == OP_LOAD) ? wdata_q : '0;

    en   = '0;
    inc  = 1'b0;
    dec  = 1'b0;
    swp1 = 1'b0;
    swp2 = 1'b1;
    bus4 = '0;
    ack0 = 1'b0;
    ack1 = 1'b0;
    err  = 1'b0;
    case (state_q)
      STAGE: begin
        en   = en_dec;
        swp1 = 1'b1;
        swp2 = 1'b0;
        bus4 = bus_val;
        inc  = (op_q == OP_INC);
        dec  = (op_q == OP_DEC);
      end
      COMMIT: begin
        en   = en_dec;
        swp2 = 1'b0;
        bus4 = bus_val;
      end
      DONE: begin
        ack0 = ~id_q;
        ack1 = id_q;
        err  = err_q;
      end
      default: ;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule
